// File: rtl/ahb_reg_pkg.sv
// Shared encodings for the USB endpoint AHB-Lite register front end:
// FSM state type, HTRANS/HSIZE codes and register word indices.
package ahb_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_BUF_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahbStateT;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;
  localparam logic [1:0] HSIZE_BAD  = 2'd3;

  localparam logic [1:0] BUF  = 2'd0;
  localparam logic [1:0] VAL0 = 2'd1;
  localparam logic [1:0] VAL1 = 2'd2;
  localparam logic [1:0] CTRL = 2'd3;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational decode of an AHB address phase into register region,
// buffer hit and ERROR classification (read-only write, bad size, misalignment).
module ahb_addr_decoder
  import ahb_reg_pkg::*;
(
  input  logic [3:0] addr,
  input  logic       write,
  input  logic [1:0] size,
  output logic [1:0] region,
  output logic       isBuf,
  output logic       isErr
);

  logic misaligned;
  logic roWrite;

  always_comb begin
    region     = addr[3:2];
    misaligned = ((size == HSIZE_HALF) && addr[0]) ||
                 ((size == HSIZE_WORD) && (addr[1:0] != 2'b00));
    roWrite    = write && ((region == VAL0) || (region == VAL1));
    isErr      = misaligned || roWrite || (size == HSIZE_BAD);
    isBuf      = (region == BUF) && !isErr;
  end

endmodule

// File: rtl/ahb_register_controller.sv
// AHB-Lite slave front end for the USB endpoint value registers and data buffer.
// Optional feature: ERROR_CLEAR_ON_READ_EN pulses errorClear on reads of the error half-word.
module ahb_register_controller
  import ahb_reg_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [1:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic              hresp,
  input  logic [15:0]       statusData,
  input  logic [15:0]       errorData,
  input  logic [7:0]        boData,
  input  logic [7:0]        ehtsData,
  output logic              bufRead,
  input  logic [DATA_W-1:0] bufRdata,
  output logic              bufWrite,
  output logic [DATA_W-1:0] bufWdata,
  output logic              ehtsWrite,
  output logic [7:0]        nextEHTSData,
  output logic              flushReq,
  output logic              errorClear
);

  ahbStateT   state, stateNext, phaseNext;
  logic       validAddr;
  logic [1:0] regionLive;
  logic       isBufLive, isErrLive;

  logic [1:0] region_p1;
  logic       isBuf_p1;
  logic       write_p1;
  logic [1:0] lane_p1;
`ifdef ERROR_CLEAR_ON_READ_EN
  logic [1:0] size_p1;
`endif

  // Wait states only in the buffer-read wait and the first ERROR cycle
  assign hready    = !((state == ST_BUF_WAIT) || (state == ST_ERR1));
  assign validAddr = hsel && hready &&
                     ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  assign bufWdata     = hwdata;
  assign nextEHTSData = hwdata[7:0];

  ahb_addr_decoder uDecoder (
    .addr   (haddr[3:0]),
    .write  (hwrite),
    .size   (hsize),
    .region (regionLive),
    .isBuf  (isBufLive),
    .isErr  (isErrLive)
  );

  always_ff @(posedge clk) begin
    if (!nRst) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Address phase -> data phase boundary
  always_ff @(posedge clk) begin
    if (validAddr) begin
      region_p1 <= regionLive;
      isBuf_p1  <= isBufLive;
      write_p1  <= hwrite;
      lane_p1   <= haddr[1:0];
`ifdef ERROR_CLEAR_ON_READ_EN
      size_p1   <= hsize;
`endif
    end
  end

  always_comb begin
    stateNext  = state;
    hresp      = 1'b0;
    hrdata     = '0;
    bufRead    = 1'b0;
    bufWrite   = 1'b0;
    ehtsWrite  = 1'b0;
    flushReq   = 1'b0;
    errorClear = 1'b0;

    if (isErrLive)                  phaseNext = ST_ERR1;
    else if (isBufLive && !hwrite)  phaseNext = ST_BUF_WAIT;
    else                            phaseNext = ST_DATA;

    case (state)
      ST_IDLE: begin
        if (validAddr) stateNext = phaseNext;
      end
      ST_DATA: begin
        stateNext = validAddr ? phaseNext : ST_IDLE;
        if (write_p1) begin
          bufWrite  = isBuf_p1;
          ehtsWrite = (region_p1 == CTRL);
          flushReq  = (region_p1 == CTRL) && (lane_p1 == 2'd1) && hwdata[8];
        end else begin
          case (region_p1)
            BUF:     hrdata = bufRdata;
            VAL0:    hrdata = {errorData, statusData};
            VAL1:    hrdata = {16'h0, ehtsData, boData};
            default: hrdata = '0;
          endcase
`ifdef ERROR_CLEAR_ON_READ_EN
          // Lanes cover [31:16]: any word read, or a half/byte read in the upper half-word
          errorClear = (region_p1 == VAL0) && (lane_p1[1] || (size_p1 == HSIZE_WORD));
`endif
        end
      end
      ST_BUF_WAIT: begin
        bufRead   = 1'b1;
        stateNext = ST_DATA;
      end
      ST_ERR1: begin
        hresp     = 1'b1;
        stateNext = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = 1'b1;
        stateNext = validAddr ? phaseNext : ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_register_controller.sv
// Table-driven, scoreboarded bench for ahb_register_controller, plus
// hand-written back-to-back, wait-state hold, reset-abort and ignored-transfer sequences.
module tb_ahb_register_controller;
  import ahb_reg_pkg::*;

`ifdef ERROR_CLEAR_ON_READ_EN
  localparam int EC = 1;
`else
  localparam int EC = 0;
`endif

  logic        tb_clk = 1'b0;
  logic        nRst;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [1:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [15:0] statusData;
  logic [15:0] errorData;
  logic [7:0]  boData;
  logic [7:0]  ehtsData;
  logic        bufRead;
  logic [31:0] bufRdata;
  logic        bufWrite;
  logic [31:0] bufWdata;
  logic        ehtsWrite;
  logic [7:0]  nextEHTSData;
  logic        flushReq;
  logic        errorClear;

  always #5 tb_clk = ~tb_clk;

  ahb_register_controller #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk          (tb_clk),
    .nRst         (nRst),
    .hsel         (hsel),
    .haddr        (haddr),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hwdata       (hwdata),
    .hrdata       (hrdata),
    .hready       (hready),
    .hresp        (hresp),
    .statusData   (statusData),
    .errorData    (errorData),
    .boData       (boData),
    .ehtsData     (ehtsData),
    .bufRead      (bufRead),
    .bufRdata     (bufRdata),
    .bufWrite     (bufWrite),
    .bufWdata     (bufWdata),
    .ehtsWrite    (ehtsWrite),
    .nextEHTSData (nextEHTSData),
    .flushReq     (flushReq),
    .errorClear   (errorClear)
  );

  typedef struct {
    int          waits;
    int          resp;
    logic [31:0] rdata;
    int          nBr;
    int          nBw;
    int          nEh;
    int          nFl;
    int          nEc;
    logic [7:0]  nextEh;
    logic [31:0] wdat;
  } resT;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] brd;
    resT         exp;
  } vecT;

  localparam int NV = 19;
  vecT vecs[NV];
  resT sbq[$];

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vecT mk(input string n, input logic [3:0] a, input logic w,
                             input logic [1:0] s, input logic [31:0] wd, input logic [31:0] brd,
                             input int wt, input int rs, input logic [31:0] rd,
                             input int br, input int bw, input int eh, input int fl, input int ec);
    vecT v;
    v.name = n; v.addr = a; v.wr = w; v.size = s; v.wdata = wd; v.brd = brd;
    v.exp.waits = wt; v.exp.resp = rs; v.exp.rdata = rd;
    v.exp.nBr = br; v.exp.nBw = bw; v.exp.nEh = eh; v.exp.nFl = fl; v.exp.nEc = ec;
    v.exp.nextEh = wd[7:0]; v.exp.wdat = wd;
    return v;
  endfunction

  task automatic compareRes(input string n, input resT o, input resT e);
    chk({n, ".waits"},  32'(o.waits), 32'(e.waits));
    chk({n, ".hresp"},  32'(o.resp),  32'(e.resp));
    chk({n, ".hrdata"}, o.rdata,      e.rdata);
    chk({n, ".bufRead"},    32'(o.nBr), 32'(e.nBr));
    chk({n, ".bufWrite"},   32'(o.nBw), 32'(e.nBw));
    chk({n, ".ehtsWrite"},  32'(o.nEh), 32'(e.nEh));
    chk({n, ".flushReq"},   32'(o.nFl), 32'(e.nFl));
    chk({n, ".errorClear"}, 32'(o.nEc), 32'(e.nEc));
    chk({n, ".nextEHTS"},   32'(o.nextEh), 32'(e.nextEh));
    chk({n, ".bufWdata"},   o.wdat, e.wdat);
  endtask

  task automatic busIdle();
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 4'h0; hwrite = 1'b0; hsize = HSIZE_WORD;
  endtask

  task automatic drivePhase(input logic [3:0] a, input logic w, input logic [1:0] s, input logic [1:0] tr);
    hsel = 1'b1; htrans = tr; haddr = a; hwrite = w; hsize = s;
  endtask

  task automatic runVec(input vecT t);
    resT o;
    bit  done;
    drivePhase(t.addr, t.wr, t.size, HTRANS_NONSEQ);
    bufRdata = t.brd;
    sbq.push_back(t.exp);
    @(posedge tb_clk); #1;
    busIdle();
    hwdata = t.wdata;
    o.waits = 0; o.resp = 0; o.rdata = '0; o.nBr = 0; o.nBw = 0; o.nEh = 0;
    o.nFl = 0; o.nEc = 0; o.nextEh = '0; o.wdat = '0;
    done = 1'b0;
    for (int c = 0; c < 6 && !done; c++) begin
      @(negedge tb_clk);
      o.waits += hready ? 0 : 1;
      o.resp  += hresp ? 1 : 0;
      o.nBr   += bufRead ? 1 : 0;
      o.nBw   += bufWrite ? 1 : 0;
      o.nEh   += ehtsWrite ? 1 : 0;
      o.nFl   += flushReq ? 1 : 0;
      o.nEc   += errorClear ? 1 : 0;
      if (hready) begin
        done = 1'b1; o.rdata = hrdata; o.nextEh = nextEHTSData; o.wdat = bufWdata;
      end
    end
    @(posedge tb_clk); #1;
    if (!done) begin
      totalCnt++;
      $display("FAIL %s.timeout: hready still low after 6 cycles, expected completion", t.name);
    end
    compareRes(t.name, o, sbq.pop_front());
    @(negedge tb_clk);
    chk({t.name, ".idleCtl"},
        {25'h0, bufRead, bufWrite, ehtsWrite, flushReq, errorClear, hresp, ~hready}, 32'h0);
    chk({t.name, ".idleRdata"}, hrdata, 32'h0);
    @(posedge tb_clk); #1;
  endtask

  initial begin
    vecs[0]  = mk("rdStat",  4'h4, 1'b0, HSIZE_WORD, 32'h0,        32'h0,        0, 0, 32'h01010201, 0, 0, 0, 0, EC);
    vecs[1]  = mk("rdBuf",   4'h0, 1'b0, HSIZE_WORD, 32'h0,        32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    vecs[2]  = mk("wrVal1",  4'h8, 1'b1, HSIZE_WORD, 32'h55,       32'h0,        1, 2, 32'h0,        0, 0, 0, 0, 0);
    vecs[3]  = mk("wrEhts",  4'hC, 1'b1, HSIZE_BYTE, 32'h3A,       32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[4]  = mk("wrFlush", 4'hD, 1'b1, HSIZE_BYTE, 32'h100,      32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0);
    vecs[5]  = mk("wrCtrlW", 4'hC, 1'b1, HSIZE_WORD, 32'h100,      32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[6]  = mk("wrBuf",   4'h0, 1'b1, HSIZE_WORD, 32'h12345678, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0);
    vecs[7]  = mk("rdVal1",  4'h8, 1'b0, HSIZE_WORD, 32'h0,        32'h0,        0, 0, 32'h00001201, 0, 0, 0, 0, 0);
    vecs[8]  = mk("rdCtrl",  4'hC, 1'b0, HSIZE_WORD, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0);
    vecs[9]  = mk("size3",   4'h0, 1'b0, HSIZE_BAD,  32'h0,        32'h1,        1, 2, 32'h0,        0, 0, 0, 0, 0);
    vecs[10] = mk("misHalf", 4'h1, 1'b0, HSIZE_HALF, 32'h0,        32'h0,        1, 2, 32'h0,        0, 0, 0, 0, 0);
    vecs[11] = mk("misWord", 4'h2, 1'b0, HSIZE_WORD, 32'h0,        32'h0,        1, 2, 32'h0,        0, 0, 0, 0, 0);
    vecs[12] = mk("rdHalf6", 4'h6, 1'b0, HSIZE_HALF, 32'h0,        32'h0,        0, 0, 32'h01010201, 0, 0, 0, 0, EC);
    vecs[13] = mk("rdByte7", 4'h7, 1'b0, HSIZE_BYTE, 32'h0,        32'h0,        0, 0, 32'h01010201, 0, 0, 0, 0, EC);
    vecs[14] = mk("rdHalf4", 4'h4, 1'b0, HSIZE_HALF, 32'h0,        32'h0,        0, 0, 32'h01010201, 0, 0, 0, 0, 0);
    vecs[15] = mk("wrVal0",  4'h4, 1'b1, HSIZE_WORD, 32'hFF,       32'h0,        1, 2, 32'h0,        0, 0, 0, 0, 0);
    vecs[16] = mk("rdBufB3", 4'h3, 1'b0, HSIZE_BYTE, 32'h0,        32'hA5A55A5A, 1, 0, 32'hA5A55A5A, 1, 0, 0, 0, 0);
    vecs[17] = mk("wrNoFl",  4'hD, 1'b1, HSIZE_BYTE, 32'h0FF,      32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[18] = mk("wrHalfD", 4'hD, 1'b1, HSIZE_HALF, 32'h100,      32'h0,        1, 2, 32'h0,        0, 0, 0, 0, 0);

    statusData = 16'h0201; errorData = 16'h0101; boData = 8'h01; ehtsData = 8'h12;
    bufRdata = 32'h0; hwdata = 32'h0;
    busIdle();

    // Reset
    nRst = 1'b0;
    @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst.ctl", {25'h0, bufRead, bufWrite, ehtsWrite, flushReq, errorClear, hresp, hready}, 32'h1);
    chk("rst.hrdata", hrdata, 32'h0);
    @(posedge tb_clk); #1;
    nRst = 1'b1;
    @(posedge tb_clk); #1;

    for (int i = 0; i < NV; i++) runVec(vecs[i]);

    // Back-to-back: buffer write then value-register read, no wait
    drivePhase(4'h0, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge tb_clk); #1;
    hwdata = 32'h12;
    drivePhase(4'h8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    @(negedge tb_clk);
    chk("b2b.bufWrite", 32'(bufWrite), 32'h1);
    chk("b2b.bufWdata", bufWdata, 32'h12);
    chk("b2b.hready1", 32'(hready), 32'h1);
    @(posedge tb_clk); #1;
    busIdle();
    @(negedge tb_clk);
    chk("b2b.hrdata", hrdata, 32'h00001201);
    chk("b2b.hready2", 32'(hready), 32'h1);
    chk("b2b.noWrite", 32'(bufWrite), 32'h0);
    @(posedge tb_clk); #1;

    // Buffer write then buffer read, with next phase held across the wait state
    drivePhase(4'h0, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge tb_clk); #1;
    hwdata = 32'hA5A5; bufRdata = 32'hCAFEF00D;
    drivePhase(4'h0, 1'b0, HSIZE_WORD, HTRANS_SEQ);
    @(negedge tb_clk);
    chk("wr2rd.bufWrite", {bufWrite, bufRead}, 32'h2);
    @(posedge tb_clk); #1;
    drivePhase(4'h8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    @(negedge tb_clk);
    chk("wr2rd.waitCtl", {bufWrite, bufRead, hready}, 32'h2);
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk("wr2rd.bufData", hrdata, 32'hCAFEF00D);
    chk("wr2rd.dataCtl", {bufRead, hready}, 32'h1);
    @(posedge tb_clk); #1;
    busIdle();
    @(negedge tb_clk);
    chk("hold.hrdata", hrdata, 32'h00001201);
    chk("hold.ctl", {bufRead, hready}, 32'h1);
    @(posedge tb_clk); #1;

    // Reset during the buffer-read wait aborts the transfer
    bufRdata = 32'h11112222;
    drivePhase(4'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge tb_clk); #1;
    busIdle();
    @(negedge tb_clk);
    chk("abort.bufRead", 32'(bufRead), 32'h1);
    nRst = 1'b0;
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk("abort.ctl", {25'h0, bufRead, bufWrite, ehtsWrite, flushReq, errorClear, hresp, hready}, 32'h1);
    chk("abort.hrdata", hrdata, 32'h0);
    nRst = 1'b1;
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk("abort.after", {25'h0, bufRead, bufWrite, ehtsWrite, flushReq, errorClear, hresp, hready}, 32'h1);
    @(posedge tb_clk); #1;

    // BUSY and unselected transfers are ignored
    hwdata = 32'h1FF;
    drivePhase(4'hD, 1'b1, HSIZE_BYTE, HTRANS_BUSY);
    @(posedge tb_clk); #1;
    busIdle();
    @(negedge tb_clk);
    chk("busy.ctl", {25'h0, bufRead, bufWrite, ehtsWrite, flushReq, errorClear, hresp, hready}, 32'h1);
    @(posedge tb_clk); #1;
    drivePhase(4'hC, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ);
    hsel = 1'b0;
    @(posedge tb_clk); #1;
    busIdle();
    @(negedge tb_clk);
    chk("nosel.ctl", {25'h0, bufRead, bufWrite, ehtsWrite, flushReq, errorClear, hresp, hready}, 32'h1);
    @(posedge tb_clk); #1;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
